// File: rtl/id_pkg.sv
// Shared decode constants and the control bundle carried by the decode stage.
package id_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  // ALU func3 values that need special operand handling
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  // Load func3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store func3
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  // Branch func3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // func7 / func6 patterns
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } imm_type_e;

  typedef struct packed {
    logic mem_ren;
    logic mem_wen;
    logic reg_wen;
    logic word_op;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/id_imm_gen.sv
// Immediate generator: picks the immediate format from the opcode and
// sign-extends it to XLEN. Purely combinational.
module id_imm_gen
  import id_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type
);

  // Fill with the sign bit first, then overwrite the low bits with the field.
  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        imm_type  = IMM_I;
        imm       = {XLEN{inst[31]}};
        imm[11:0] = inst[31:20];
      end
      OPC_STORE: begin
        imm_type  = IMM_S;
        imm       = {XLEN{inst[31]}};
        imm[11:0] = {inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        imm_type  = IMM_B;
        imm       = {XLEN{inst[31]}};
        imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        imm_type  = IMM_J;
        imm       = {XLEN{inst[31]}};
        imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type  = IMM_U;
        imm       = {XLEN{inst[31]}};
        imm[31:0] = {inst[31:12], 12'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Registered RV32/RV64 decode stage: decodes, reads the register file,
// detects load-use hazards against EX and holds the result in one output register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// Upstream: accept = in_valid_i && in_ready_o; in_ready_o never depends on in_valid_i.
// Downstream: once out_valid_o is 1 the output register is frozen until out_ready_i is 1.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            ex_load_vld_i,
  input  logic [4:0]      ex_load_rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] rs2_store_o,
  output logic [XLEN-1:0] base_addr_o,
  output logic [XLEN-1:0] offset_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic            mem_ren_o,
  output logic            mem_wen_o,
  output logic            word_op_o,
  output logic            illegal_o
);

  localparam int SHW  = $clog2(XLEN);
  localparam bit IS64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] f6;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign f6     = inst_i[31:26];

  logic [XLEN-1:0] imm;
  imm_type_e       imm_type;

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst     (inst_i),
    .imm      (imm),
    .imm_type (imm_type)
  );

  // Decoded (combinational) view of the instruction at the input
  logic            use_rs1, use_rs2, rd_wr, ill;
  ctrl_t           dec_ctrl;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_op1, dec_op2, dec_base, dec_offset, dec_store;

  // Opcode/func decode, operand selection and legality; illegal encodings clear everything else.
  always_comb begin
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    rd_wr      = 1'b0;
    ill        = 1'b0;
    dec_ctrl   = '0;
    dec_rd     = '0;
    dec_op1    = '0;
    dec_op2    = (imm_type == IMM_NONE) ? rs2_data_i : imm;
    dec_base   = '0;
    dec_offset = '0;
    dec_store  = '0;
    case (opcode)
      OPC_OP_IMM: begin
        use_rs1 = 1'b1;
        rd_wr   = 1'b1;
        dec_op1 = rs1_data_i;
        if (f3 == F3_SLL || f3 == F3_SR) begin
          dec_op2          = '0;
          dec_op2[SHW-1:0] = inst_i[20 +: SHW];
          // bit 25 is shamt[5] on RV64 but must be zero on RV32
          ill = (!IS64 && inst_i[25]) ||
                !((f6 == F6_BASE) || (f3 == F3_SR && f6 == F6_ALT));
        end
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        rd_wr   = 1'b1;
        dec_op1 = rs1_data_i;
        dec_op2 = rs2_data_i;
        if (f3 == F3_SLL || f3 == F3_SR) begin
          dec_op2          = '0;
          dec_op2[SHW-1:0] = rs2_data_i[SHW-1:0];
        end
        ill = !((f7 == F7_BASE) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
      end
      OPC_OP_IMM_32: begin
        use_rs1          = 1'b1;
        rd_wr            = 1'b1;
        dec_ctrl.word_op = 1'b1;
        dec_op1          = rs1_data_i;
        if (f3 == F3_SLL || f3 == F3_SR) begin
          dec_op2      = '0;
          dec_op2[4:0] = inst_i[24:20];
        end
        case (f3)
          F3_ADD:  ill = 1'b0;
          F3_SLL:  ill = (f7 != F7_BASE);
          F3_SR:   ill = !(f7 == F7_BASE || f7 == F7_ALT);
          default: ill = 1'b1;
        endcase
        if (!IS64) ill = 1'b1;
      end
      OPC_OP_32: begin
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
        rd_wr            = 1'b1;
        dec_ctrl.word_op = 1'b1;
        dec_op1          = rs1_data_i;
        dec_op2          = rs2_data_i;
        if (f3 == F3_SLL || f3 == F3_SR) begin
          dec_op2      = '0;
          dec_op2[4:0] = rs2_data_i[4:0];
        end
        case (f3)
          F3_ADD, F3_SR: ill = !(f7 == F7_BASE || f7 == F7_ALT);
          F3_SLL:        ill = (f7 != F7_BASE);
          default:       ill = 1'b1;
        endcase
        if (!IS64) ill = 1'b1;
      end
      OPC_LOAD: begin
        use_rs1          = 1'b1;
        rd_wr            = 1'b1;
        dec_ctrl.mem_ren = 1'b1;
        dec_op1          = rs1_data_i;
        dec_op2          = imm;
        dec_base         = rs1_data_i;
        dec_offset       = imm;
        case (f3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ill = 1'b0;
          F3_LD, F3_LWU:                       ill = !IS64;
          default:                             ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
        dec_ctrl.mem_wen = 1'b1;
        dec_op1          = rs1_data_i;
        dec_op2          = imm;
        dec_base         = rs1_data_i;
        dec_offset       = imm;
        dec_store        = rs2_data_i;
        case (f3)
          F3_SB, F3_SH, F3_SW: ill = 1'b0;
          F3_SD:               ill = !IS64;
          default:             ill = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec_op1    = rs1_data_i;
        dec_op2    = rs2_data_i;
        dec_base   = inst_addr_i;
        dec_offset = imm;
        case (f3)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: ill = 1'b0;
          default:                                         ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        rd_wr      = 1'b1;
        dec_op1    = inst_addr_i;
        dec_op2    = imm;
        dec_base   = inst_addr_i;
        dec_offset = imm;
      end
      OPC_JALR: begin
        use_rs1    = 1'b1;
        rd_wr      = 1'b1;
        dec_op1    = rs1_data_i;
        dec_op2    = imm;
        dec_base   = rs1_data_i;
        dec_offset = imm;
        ill        = (f3 != 3'b000);
      end
      OPC_LUI: begin
        rd_wr   = 1'b1;
        dec_op1 = '0;
        dec_op2 = imm;
      end
      OPC_AUIPC: begin
        rd_wr   = 1'b1;
        dec_op1 = inst_addr_i;
        dec_op2 = imm;
      end
      default: ill = 1'b1;
    endcase

    if (ill) begin
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      rd_wr      = 1'b0;
      dec_ctrl   = '0;
      dec_op1    = '0;
      dec_op2    = '0;
      dec_base   = '0;
      dec_offset = '0;
      dec_store  = '0;
    end
    dec_ctrl.illegal = ill;
    dec_rd           = rd_wr ? inst_i[11:7] : 5'd0;
    dec_ctrl.reg_wen = rd_wr && (dec_rd != 5'd0);
  end

  // Unused source fields read as x0 so they never match a pending load.
  assign rs1_addr_o = use_rs1 ? inst_i[19:15] : 5'd0;
  assign rs2_addr_o = use_rs2 ? inst_i[24:20] : 5'd0;

  logic hazard, accept;
  logic out_valid_q;

  assign hazard = ex_load_vld_i && (ex_load_rd_i != 5'd0) &&
                  ((ex_load_rd_i == rs1_addr_o) || (ex_load_rd_i == rs2_addr_o));
  assign in_ready_o = !hazard && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  ctrl_t ctrl_q;

  // Output register: reset > flush > accept > drain; data fields only change on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      inst_o        <= '0;
      inst_addr_o   <= '0;
      op1_o         <= '0;
      op2_o         <= '0;
      rs2_store_o   <= '0;
      base_addr_o   <= '0;
      offset_addr_o <= '0;
      rd_addr_o     <= '0;
      ctrl_q        <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      inst_o        <= inst_i;
      inst_addr_o   <= inst_addr_i;
      op1_o         <= dec_op1;
      op2_o         <= dec_op2;
      rs2_store_o   <= dec_store;
      base_addr_o   <= dec_base;
      offset_addr_o <= dec_offset;
      rd_addr_o     <= dec_rd;
      ctrl_q        <= dec_ctrl;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign reg_wen_o   = ctrl_q.reg_wen;
  assign mem_ren_o   = ctrl_q.mem_ren;
  assign mem_wen_o   = ctrl_q.mem_wen;
  assign word_op_o   = ctrl_q.word_op;
  assign illegal_o   = ctrl_q.illegal;

endmodule
